// File: rtl/exc_arbiter.sv
// MEM-stage exception collector feeding CP0: prioritised exception code, EPC, BadVAddr, BD flag and IP lines.
// Define EXC_INT_SYNC_EN to insert a 2-flop synchroniser on ext_int_i ahead of the IP register.

`ifndef EC_None
`define EC_None 5'h1f
`endif
`ifndef EC_Eret
`define EC_Eret 5'h10
`endif

module exc_arbiter #(
  parameter int INT_WIDTH     = 6,
  parameter int TIMER_IRQ_BIT = 5
) (
  input  logic                 cpu_clk_75M,
  input  logic                 cpu_rst_n,
  input  logic                 stall_i,
  input  logic                 flush_i,
  input  logic                 inst_valid_i,
  input  logic [31:0]          pc_i,
  input  logic                 in_delay_i,
  input  logic                 if_adel_i,
  input  logic                 id_ri_i,
  input  logic                 id_sys_i,
  input  logic                 id_bp_i,
  input  logic                 id_eret_i,
  input  logic                 ex_ov_i,
  input  logic                 mem_adel_i,
  input  logic                 mem_ades_i,
  input  logic [31:0]          mem_addr_i,
  input  logic [INT_WIDTH-1:0] ext_int_i,
  input  logic                 int_time_i,
  input  logic [31:0]          status_i,
  output logic [INT_WIDTH-1:0] cp0_int_o,
  output logic [4:0]           exc_code_o,
  output logic [31:0]          exc_epc_o,
  output logic [31:0]          exc_badvaddr_o,
  output logic                 in_delay_o,
  output logic                 mem_kill_o
);

  typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

  state_t                 state_reg;
  state_t                 state_next;
  logic [INT_WIDTH-1:0]   ip_reg;
  logic [INT_WIDTH-1:0]   ip_next;
  logic [INT_WIDTH-1:0]   ext_int_s;
  logic                   int_req;
  logic                   commit;
  logic                   reported;
  logic [4:0]             code;
  logic [31:0]            badvaddr;
  logic                   unused_status;

  assign unused_status = ^{status_i[31:10+INT_WIDTH], status_i[9:2]};

`ifdef EXC_INT_SYNC_EN
  logic [INT_WIDTH-1:0] sync1_reg;
  logic [INT_WIDTH-1:0] sync2_reg;

  always_ff @(posedge cpu_clk_75M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= ext_int_i;
      sync2_reg <= sync1_reg;
    end
  end

  assign ext_int_s = sync2_reg;
`else
  assign ext_int_s = ext_int_i;
`endif

  // The CP0 timer bypasses any synchroniser: it is already in this clock domain.
  for (genvar gi = 0; gi < INT_WIDTH; gi++) begin : g_ip
    if (gi == TIMER_IRQ_BIT) begin : g_timer
      assign ip_next[gi] = ext_int_s[gi] | int_time_i;
    end else begin : g_ext
      assign ip_next[gi] = ext_int_s[gi];
    end
  end

  always_ff @(posedge cpu_clk_75M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      ip_reg <= '0;
    end else begin
      ip_reg <= ip_next;
    end
  end

  assign cp0_int_o = ip_reg;
  assign int_req   = (|(ip_reg & status_i[10 +: INT_WIDTH])) & status_i[0] & ~status_i[1];

  // Outputs go idle while reset is held even though they are combinational from inputs.
  assign commit = cpu_rst_n & inst_valid_i & ~stall_i & ~flush_i & (state_reg == RUN);

  // State register
  always_ff @(posedge cpu_clk_75M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state: one HOLD cycle after any report lets CP0's flush and EXL settle.
  always_comb begin
    state_next = RUN;
    if ((state_reg == RUN) && reported) begin
      state_next = HOLD;
    end
  end

  // Output logic: prioritised exception selection
  always_comb begin
    code     = `EC_None;
    badvaddr = '0;
    if (commit) begin
      if (int_req) begin
        code = 5'h00;
      end else if (if_adel_i) begin
        code     = 5'h04;
        badvaddr = pc_i;
      end else if (id_ri_i) begin
        code = 5'h0a;
      end else if (id_sys_i) begin
        code = 5'h08;
      end else if (id_bp_i) begin
        code = 5'h09;
      end else if (ex_ov_i) begin
        code = 5'h0c;
      end else if (mem_adel_i) begin
        code     = 5'h04;
        badvaddr = mem_addr_i;
      end else if (mem_ades_i) begin
        code     = 5'h05;
        badvaddr = mem_addr_i;
      end else if (id_eret_i) begin
        code = `EC_Eret;
      end
    end
  end

  assign reported       = (code != `EC_None);
  assign exc_code_o     = code;
  assign exc_badvaddr_o = badvaddr;
  assign exc_epc_o      = reported ? (in_delay_i ? pc_i - 32'd4 : pc_i) : 32'd0;
  assign in_delay_o     = in_delay_i & reported;
  assign mem_kill_o     = reported;

endmodule

// File: tb/tb_exc_arbiter.sv
// Self-checking bench for exc_arbiter: reset, hand-written vector table, multi-cycle sequences, random vs. reference model.
// Follows EXC_INT_SYNC_EN for the expected external-interrupt latency.

module tb_exc_arbiter;

  localparam logic [4:0] NONE = 5'h1f;
  localparam logic [4:0] ERET = 5'h10;
`ifdef EXC_INT_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic        cpu_clk_75M = 1'b0;
  logic        cpu_rst_n;
  logic        stall_i, flush_i, inst_valid_i, in_delay_i;
  logic        if_adel_i, id_ri_i, id_sys_i, id_bp_i, id_eret_i, ex_ov_i, mem_adel_i, mem_ades_i;
  logic [31:0] pc_i, mem_addr_i, status_i;
  logic [5:0]  ext_int_i;
  logic        int_time_i;
  logic [5:0]  cp0_int_o;
  logic [4:0]  exc_code_o;
  logic [31:0] exc_epc_o, exc_badvaddr_o;
  logic        in_delay_o, mem_kill_o;

  int vectors = 0;
  int miscompares = 0;

  always #5 cpu_clk_75M = ~cpu_clk_75M;

  exc_arbiter dut (
    .cpu_clk_75M    (cpu_clk_75M),
    .cpu_rst_n      (cpu_rst_n),
    .stall_i        (stall_i),
    .flush_i        (flush_i),
    .inst_valid_i   (inst_valid_i),
    .pc_i           (pc_i),
    .in_delay_i     (in_delay_i),
    .if_adel_i      (if_adel_i),
    .id_ri_i        (id_ri_i),
    .id_sys_i       (id_sys_i),
    .id_bp_i        (id_bp_i),
    .id_eret_i      (id_eret_i),
    .ex_ov_i        (ex_ov_i),
    .mem_adel_i     (mem_adel_i),
    .mem_ades_i     (mem_ades_i),
    .mem_addr_i     (mem_addr_i),
    .ext_int_i      (ext_int_i),
    .int_time_i     (int_time_i),
    .status_i       (status_i),
    .cp0_int_o      (cp0_int_o),
    .exc_code_o     (exc_code_o),
    .exc_epc_o      (exc_epc_o),
    .exc_badvaddr_o (exc_badvaddr_o),
    .in_delay_o     (in_delay_o),
    .mem_kill_o     (mem_kill_o)
  );

  // ctl = {stall, flush, valid, in_delay}; flags = {if_adel, id_ri, id_sys, id_bp, ex_ov, mem_adel, mem_ades, id_eret}
  typedef struct {
    logic [3:0]  ctl;
    logic [7:0]  flags;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [4:0]  e_code;
    logic [31:0] e_epc;
    logic [31:0] e_bva;
    logic        e_bd;
    logic        e_kill;
  } vec_t;

  vec_t table_q[$];

  task automatic add(input logic [3:0] ctl, input logic [7:0] flags, input logic [31:0] pc, input logic [31:0] addr,
                     input logic [4:0] e_code, input logic [31:0] e_epc, input logic [31:0] e_bva,
                     input logic e_bd, input logic e_kill);
    vec_t v;
    v.ctl = ctl; v.flags = flags; v.pc = pc; v.addr = addr;
    v.e_code = e_code; v.e_epc = e_epc; v.e_bva = e_bva; v.e_bd = e_bd; v.e_kill = e_kill;
    table_q.push_back(v);
  endtask

  task automatic check(input string name, input logic [5:0] e_int, input logic [4:0] e_code,
                       input logic [31:0] e_epc, input logic [31:0] e_bva, input logic e_bd, input logic e_kill);
    vectors++;
    if (cp0_int_o !== e_int || exc_code_o !== e_code || exc_epc_o !== e_epc ||
        exc_badvaddr_o !== e_bva || in_delay_o !== e_bd || mem_kill_o !== e_kill) begin
      miscompares++;
      $display("FAIL %s: got int=%h code=%h epc=%h bva=%h bd=%b kill=%b, want int=%h code=%h epc=%h bva=%h bd=%b kill=%b",
               name, cp0_int_o, exc_code_o, exc_epc_o, exc_badvaddr_o, in_delay_o, mem_kill_o,
               e_int, e_code, e_epc, e_bva, e_bd, e_kill);
    end
  endtask

  task automatic set_flags(input logic [7:0] f);
    {if_adel_i, id_ri_i, id_sys_i, id_bp_i, ex_ov_i, mem_adel_i, mem_ades_i, id_eret_i} = f;
  endtask

  task automatic idle();
    stall_i = 0; flush_i = 0; inst_valid_i = 0; in_delay_i = 0;
    set_flags(8'h00);
    pc_i = 32'h0; mem_addr_i = 32'h0;
  endtask

  task automatic next_cycle();
    @(posedge cpu_clk_75M);
    #1;
  endtask

  // Reference model state
  logic [5:0] ext_hist [3];
  logic       timer_prev;
  logic       m_hold;

  task automatic model_clear();
    for (int i = 0; i < 3; i++) ext_hist[i] = 6'h0;
    timer_prev = 1'b0;
    m_hold     = 1'b0;
  endtask

  task automatic randomize_inputs();
    logic [7:0] f;
    stall_i      = ($urandom_range(0, 99) < 15);
    flush_i      = ($urandom_range(0, 99) < 10);
    inst_valid_i = ($urandom_range(0, 99) < 80);
    in_delay_i   = ($urandom_range(0, 99) < 30);
    for (int b = 0; b < 8; b++) f[b] = ($urandom_range(0, 7) == 0);
    set_flags(f);
    pc_i       = $urandom;
    mem_addr_i = $urandom;
    ext_int_i  = 6'($urandom);
    int_time_i = ($urandom_range(0, 3) == 0);
    status_i   = {16'h0, 6'($urandom), 8'h0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0)};
  endtask

  initial begin
    logic [4:0]  codes [9];
    logic        hits  [9];
    logic [5:0]  ip_m;
    logic        ireq, found;
    logic [4:0]  e_code;
    logic [31:0] e_bva, e_epc;

    codes = '{5'h00, 5'h04, 5'h0a, 5'h08, 5'h09, 5'h0c, 5'h04, 5'h05, ERET};

    // Reset held with random inputs
    cpu_rst_n = 0;
    randomize_inputs();
    for (int k = 0; k < 4; k++) begin
      randomize_inputs();
      inst_valid_i = 1; stall_i = 0; flush_i = 0; ex_ov_i = 1;
      @(negedge cpu_clk_75M);
      check("reset", 6'h00, NONE, 32'h0, 32'h0, 1'b0, 1'b0);
      $display("reset cycle %0d code=%h", k, exc_code_o);
      next_cycle();
    end
    idle(); ext_int_i = 0; int_time_i = 0; status_i = 0;
    cpu_rst_n = 1;
    next_cycle();

    add(4'b0010, 8'b1000_1000, 32'h8000_0010, 32'h0,         5'h04, 32'h8000_0010, 32'h8000_0010, 0, 1);
    add(4'b0011, 8'b0010_0000, 32'hBFC0_0104, 32'h0,         5'h08, 32'hBFC0_0100, 32'h0,         1, 1);
    add(4'b0010, 8'b0110_0000, 32'h0000_0100, 32'h0,         5'h0a, 32'h0000_0100, 32'h0,         0, 1);
    add(4'b0010, 8'b0011_0000, 32'h0000_0200, 32'h0,         5'h08, 32'h0000_0200, 32'h0,         0, 1);
    add(4'b0010, 8'b0001_1000, 32'h0000_0300, 32'h0,         5'h09, 32'h0000_0300, 32'h0,         0, 1);
    add(4'b0010, 8'b0000_1100, 32'h0000_0400, 32'h1111_0000, 5'h0c, 32'h0000_0400, 32'h0,         0, 1);
    add(4'b0010, 8'b0000_0110, 32'h0000_0500, 32'h1234_5679, 5'h04, 32'h0000_0500, 32'h1234_5679, 0, 1);
    add(4'b0011, 8'b0000_0011, 32'h0000_0604, 32'h0000_0002, 5'h05, 32'h0000_0600, 32'h0000_0002, 1, 1);
    add(4'b0011, 8'b0000_0001, 32'h0000_0000, 32'h0,         ERET,  32'hFFFF_FFFC, 32'h0,         1, 1);
    add(4'b0000, 8'b0100_0000, 32'h0000_0700, 32'h0,         NONE,  32'h0,         32'h0,         0, 0);
    add(4'b1010, 8'b0000_0010, 32'h0000_0800, 32'h0000_0008, NONE,  32'h0,         32'h0,         0, 0);
    add(4'b1110, 8'b0000_0010, 32'h0000_0900, 32'h0000_0008, NONE,  32'h0,         32'h0,         0, 0);
    add(4'b0011, 8'b0000_0000, 32'h0000_0a00, 32'h0,         NONE,  32'h0,         32'h0,         0, 0);

    foreach (table_q[i]) begin
      {stall_i, flush_i, inst_valid_i, in_delay_i} = table_q[i].ctl;
      set_flags(table_q[i].flags);
      pc_i = table_q[i].pc; mem_addr_i = table_q[i].addr;
      @(negedge cpu_clk_75M);
      check($sformatf("table%0d", i), 6'h00, table_q[i].e_code, table_q[i].e_epc,
            table_q[i].e_bva, table_q[i].e_bd, table_q[i].e_kill);
      $display("table vector %0d code=%h epc=%h bva=%h", i, exc_code_o, exc_epc_o, exc_badvaddr_o);
      next_cycle();
      idle();
      next_cycle();
    end

    // Priority report followed by one HOLD cycle, then reported again
    inst_valid_i = 1; pc_i = 32'h8000_0010; if_adel_i = 1; ex_ov_i = 1;
    @(negedge cpu_clk_75M); check("prio_run", 6'h00, 5'h04, 32'h8000_0010, 32'h8000_0010, 0, 1);
    $display("prio run code=%h", exc_code_o);
    next_cycle();
    @(negedge cpu_clk_75M); check("prio_hold", 6'h00, NONE, 32'h0, 32'h0, 0, 0);
    $display("prio hold code=%h", exc_code_o);
    next_cycle();
    @(negedge cpu_clk_75M); check("prio_rerun", 6'h00, 5'h04, 32'h8000_0010, 32'h8000_0010, 0, 1);
    $display("prio rerun code=%h", exc_code_o);
    next_cycle(); idle(); next_cycle();

    // Stall / flush / release
    inst_valid_i = 1; pc_i = 32'h0000_1000; mem_addr_i = 32'hA000_0003; mem_ades_i = 1; stall_i = 1;
    @(negedge cpu_clk_75M); check("stall", 6'h00, NONE, 32'h0, 32'h0, 0, 0);
    $display("stall code=%h kill=%b", exc_code_o, mem_kill_o);
    next_cycle(); flush_i = 1;
    @(negedge cpu_clk_75M); check("stall_flush", 6'h00, NONE, 32'h0, 32'h0, 0, 0);
    $display("stall+flush code=%h", exc_code_o);
    next_cycle(); stall_i = 0;
    @(negedge cpu_clk_75M); check("flush", 6'h00, NONE, 32'h0, 32'h0, 0, 0);
    $display("flush code=%h", exc_code_o);
    next_cycle(); flush_i = 0;
    @(negedge cpu_clk_75M); check("release", 6'h00, 5'h05, 32'h0000_1000, 32'hA000_0003, 0, 1);
    $display("release code=%h bva=%h", exc_code_o, exc_badvaddr_o);
    next_cycle(); idle(); next_cycle();

    // Async reset during HOLD returns straight to RUN
    inst_valid_i = 1; pc_i = 32'h0000_2000; ex_ov_i = 1;
    @(negedge cpu_clk_75M); check("arst_pre", 6'h00, 5'h0c, 32'h0000_2000, 32'h0, 0, 1);
    @(posedge cpu_clk_75M); #1 cpu_rst_n = 0;
    #1 check("arst_mid", 6'h00, NONE, 32'h0, 32'h0, 0, 0);
    #1 cpu_rst_n = 1;
    @(negedge cpu_clk_75M); check("arst_run", 6'h00, 5'h0c, 32'h0000_2000, 32'h0, 0, 1);
    $display("async reset in hold code=%h", exc_code_o);
    next_cycle(); idle(); next_cycle();

    // External interrupt latency, then take
    inst_valid_i = 1; pc_i = 32'h8000_0200; status_i = 32'h0000_0401; ext_int_i = 6'h01;
    for (int k = 0; k <= LAT; k++) begin
      @(negedge cpu_clk_75M);
      if (k < LAT) check("int_wait", 6'h00, NONE, 32'h0, 32'h0, 0, 0);
      else         check("int_take", 6'h01, 5'h00, 32'h8000_0200, 32'h0, 0, 1);
      $display("int cycle %0d ip=%h code=%h", k, cp0_int_o, exc_code_o);
      next_cycle();
    end
    @(negedge cpu_clk_75M); check("int_hold", 6'h01, NONE, 32'h0, 32'h0, 0, 0);
    next_cycle();
    status_i = 32'h0000_0403;
    for (int k = 0; k < 2; k++) begin
      @(negedge cpu_clk_75M); check("int_exl", 6'h01, NONE, 32'h0, 32'h0, 0, 0);
      $display("int masked by EXL code=%h", exc_code_o);
      next_cycle();
    end

    // Timer interrupt always has 1-cycle latency
    inst_valid_i = 0; ext_int_i = 6'h00; int_time_i = 1; status_i = 32'h0000_8001;
    repeat (LAT + 1) next_cycle();
    inst_valid_i = 1; pc_i = 32'h8000_0300;
    @(negedge cpu_clk_75M); check("timer", 6'h20, 5'h00, 32'h8000_0300, 32'h0, 0, 1);
    $display("timer ip=%h code=%h", cp0_int_o, exc_code_o);
    next_cycle(); idle(); int_time_i = 0; status_i = 0;

    // Randomized run against the reference model
    cpu_rst_n = 0; next_cycle(); next_cycle(); cpu_rst_n = 1;
    model_clear();
    next_cycle();
    for (int n = 0; n < 2000; n++) begin
      randomize_inputs();
      @(negedge cpu_clk_75M);
      ip_m = ext_hist[LAT-1];
      ip_m[5] = ip_m[5] | timer_prev;
      ireq = (|(ip_m & status_i[15:10])) && status_i[0] && !status_i[1];
      hits = '{ireq, if_adel_i, id_ri_i, id_sys_i, id_bp_i, ex_ov_i, mem_adel_i, mem_ades_i, id_eret_i};
      found = 0; e_code = NONE; e_bva = 0;
      if (inst_valid_i && !stall_i && !flush_i && !m_hold) begin
        for (int i = 0; i < 9; i++) begin
          if (!found && hits[i]) begin
            found  = 1;
            e_code = codes[i];
            if (i == 1) e_bva = pc_i;
            if (i == 6 || i == 7) e_bva = mem_addr_i;
          end
        end
      end
      e_epc = found ? (in_delay_i ? pc_i - 32'd4 : pc_i) : 32'd0;
      check($sformatf("rand%0d", n), ip_m, e_code, e_epc, e_bva, found & in_delay_i, found);
      $display("rand %0d ip=%h code=%h", n, cp0_int_o, exc_code_o);
      ext_hist[2] = ext_hist[1];
      ext_hist[1] = ext_hist[0];
      ext_hist[0] = ext_int_i;
      timer_prev  = int_time_i;
      m_hold      = found;
      next_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
